sender: RTL and testbench
=========================

Name: sender

Overview:
- UART-style serial transmitter: on request, sends one 8-bit byte as an 8N1 frame on a single line.
- Frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between a byte producer (level-sensitive enable handshake) and an off-chip serial TX pin.
- Pulses tx_done for one cycle when the frame's stop bit completes.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate in bits/s.
- BIT_CYCLES, CLK_FREQ/BAUD (434 at defaults), clock cycles per bit. Integer division, truncated. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. Asserting it (1) resets immediately.
- en  input  1  level request to send; sampled only while idle.
- data  input  8  byte to transmit; captured at frame start.
- tx  output  1  serial line; idles high.
- tx_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset (rst_n=1, asynchronous): state=IDLE, tx=1, tx_done=0, bit counter=0, baud counter=0, shift register=0. Reset mid-frame aborts the frame; tx returns high immediately.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0], 8 bits.
  - STOP: tx=1.
- IDLE -> START at the first rising edge where en=1.
  - On that edge, data is latched into the shift register.
  - tx drives 0 from that edge.
  - Later changes to data do not affect the frame in progress.
- Each bit lasts exactly BIT_CYCLES clocks. Baud counter runs 0..BIT_CYCLES-1 and clears on each bit boundary.
- START -> DATA after BIT_CYCLES clocks.
- DATA: bits sent in order data[0]..data[7]. Shift register shifts right at each bit boundary. After the 8th bit, go to STOP.
- STOP: after BIT_CYCLES clocks, assert tx_done=1 for exactly one cycle and go to IDLE on the same edge.
- Frame length: 10*BIT_CYCLES clocks from the start edge to the tx_done edge (4340 clocks at defaults).
- en is ignored while a frame is active; no queuing.
- If en is still 1 on the first IDLE edge after tx_done, a new frame starts immediately. tx then stays 1 for one cycle between the stop bit and the next start bit.
- tx and tx_done are registered outputs, glitch-free.
- tx_done=0 in all cycles except the terminal cycle of STOP.

Test Plan:
- Reset: hold rst_n=1 for 10 cycles with en=1, data=8'hFF -> tx=1, tx_done=0 throughout; no frame starts.
- Single frame, data=8'b11010011, en=1 until tx_done:
  - tx sequence per 434-clock bit: 0,1,1,0,0,1,0,1,1,1.
  - tx_done pulses once, 4340 clocks after start, width 1 cycle.
- Second frame after 50 µs idle, data=8'b00111010:
  - tx sequence: 0,0,1,0,1,1,1,0,0,1.
  - Exactly one tx_done pulse.
  - tx=1 during the idle gap.
- Data change mid-frame: start with 8'hA5, switch data to 8'h00 after 2 bits -> line still carries A5 (1,0,1,0,0,1,0,1 LSB first).
- Back-to-back: keep en=1 through tx_done -> second frame's start bit begins 1 cycle after tx_done. No extra tx_done pulses.
- Async reset mid-DATA: assert rst_n=1 between clock edges -> tx=1 immediately. After release with en=0 -> stays IDLE, no tx_done.

Source files
------------

// File: rtl/sender.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit.
// Two-process FSM; tx and tx_done come straight from flops.
module sender #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_done
);

    localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // rst_n is active high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (en) begin
                    state_d = StStart;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end

            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        // Next bit is the one about to land in shift[0].
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_sender.sv
// Directed bench for sender at default parameters (434 clocks per bit).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sender;

    localparam int B = 434;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       tx;
    logic       tx_done;

    int n_checks;
    int n_errors;

    sender dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .data    (data),
        .tx      (tx),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({tag, " tx"}, tx, 1'b1);
            check({tag, " done"}, tx_done, 1'b0);
        end
    endtask

    // Called just after an edge with en already 1: the next edge starts the frame.
    // seq[k] is the expected line level during bit k (k=0 start, k=9 stop).
    task automatic run_frame(input string tag, input logic [9:0] seq, input bit change,
                             input logic [7:0] new_data, input bit keep_en);
        for (int c = 0; c < 10 * B; c++) begin
            @(posedge clk); #1;
            check({tag, " tx"}, tx, seq[c / B]);
            check({tag, " done"}, tx_done, 1'b0);
            if (change && c == 2 * B - 1) data = new_data;
        end
        @(posedge clk); #1;
        check({tag, " done pulse"}, tx_done, 1'b1);
        check({tag, " tx at done"}, tx, 1'b1);
        if (!keep_en) en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        en       = 1'b1;
        data     = 8'hFF;

        // Held in reset with a pending request: line must stay idle.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("reset tx", tx, 1'b1);
            check("reset done", tx_done, 1'b0);
        end
        en    = 1'b0;
        rst_n = 1'b0;
        idle_cycles("post reset idle", 20);

        // 0xD3 -> 0,1,1,0,0,1,0,1,1,1
        data = 8'hD3;
        en   = 1'b1;
        run_frame("frame d3", 10'b1110100110, 1'b0, 8'h00, 1'b0);

        // 50 us gap at 50 MHz
        idle_cycles("gap", 2500);

        // 0x3A -> 0,0,1,0,1,1,1,0,0,1
        data = 8'h3A;
        en   = 1'b1;
        run_frame("frame 3a", 10'b1001110100, 1'b0, 8'h00, 1'b0);
        idle_cycles("after 3a", 5);

        // 0xA5, data changed to 0x00 after two bits: line still carries A5.
        data = 8'hA5;
        en   = 1'b1;
        run_frame("frame a5", 10'b1101001010, 1'b1, 8'h00, 1'b0);
        idle_cycles("after a5", 5);

        // Back-to-back: 0x0F then 0x80, en held through the first tx_done.
        data = 8'h0F;
        en   = 1'b1;
        run_frame("b2b 0f", 10'b1000011110, 1'b1, 8'h80, 1'b1);
        run_frame("b2b 80", 10'b1100000000, 1'b0, 8'h00, 1'b0);
        idle_cycles("after b2b", 5);

        // Async reset in the middle of a zero data bit.
        data = 8'h00;
        en   = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2 * B + 10) @(posedge clk);
        #1;
        check("pre-reset tx low", tx, 1'b0);
        #4;
        rst_n = 1'b1;
        #1;
        check("async reset tx", tx, 1'b1);
        check("async reset done", tx_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("in reset tx", tx, 1'b1);
        end
        rst_n = 1'b0;
        idle_cycles("after abort", 2 * B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
